// File: rtl/rms_meter_pkg.sv
// Shared widths and sqrt FSM state type for the RMS amplitude meter.
// Optional peak tracking is enabled with RMS_PEAK_HOLD_EN.
package rms_meter_pkg;

  localparam int DW         = 22;
  localparam int LOG2_N_DEF = 4;
  localparam int ACC_W      = 2*DW-1+LOG2_N_DEF;
  localparam int RAD_W      = 2*DW;
  localparam int IT_W       = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sqrt_state_e;

endpackage

// File: rtl/isqrt_seq.sv
// Restoring integer square root, one root bit per clock, MSB first.
// A start in IDLE or DONE loads a new radicand; starts during RUN are ignored.
module isqrt_seq
  import rms_meter_pkg::*;
#(
  parameter int W = DW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [2*W-1:0] i_radicand,
  output logic [W-1:0]   o_root,
  output logic           o_done,
  output logic           o_busy
);

  localparam int IW = $clog2(W);

  sqrt_state_e    r_state;
  sqrt_state_e    w_state_nx;
  logic [IW-1:0]  r_iter;
  logic [2*W-1:0] r_rad;
  logic [W:0]     r_rem;
  logic [W-1:0]   r_root;

  logic [W+2:0]   w_cat;
  logic [W+1:0]   w_sub;
  logic [W:0]     w_diff;
  logic           w_take;
  logic           w_load;

  assign w_cat  = {r_rem, r_rad[2*W-1 -: 2]};
  assign w_sub  = {r_root, 2'b01};
  assign w_take = (w_cat >= {1'b0, w_sub});
  // Low bits suffice: a taken trial always fits the remainder width.
  assign w_diff = w_cat[W:0] - w_sub[W:0];
  assign w_load = i_start && (r_state != RUN);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nx = RUN;
      RUN:     if (r_iter == '0) w_state_nx = DONE;
      DONE:    w_state_nx = i_start ? RUN : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_rad  <= i_radicand;
        r_rem  <= '0;
        r_root <= '0;
        r_iter <= IW'(W-1);
      end else if (r_state == RUN) begin
        r_rad  <= r_rad << 2;
        r_root <= {r_root[W-2:0], w_take};
        r_rem  <= w_take ? w_diff : w_cat[W:0];
        r_iter <= r_iter - 1'b1;
      end
    end
  end

  assign o_root = r_root;
  assign o_done = (r_state == DONE);
  assign o_busy = (r_state == RUN);

endmodule

// File: rtl/rms_amplitude_meter.sv
// Block-window RMS meter: sum of squares, mean by shift, sequential sqrt.
// Define RMS_PEAK_HOLD_EN to add the per-window peak_out output.
module rms_amplitude_meter
  import rms_meter_pkg::*;
#(
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic [DW-1:0] rms_out,
  output logic          rms_valid,
  output logic          busy,
  output logic          overrun
`ifdef RMS_PEAK_HOLD_EN
  ,
  output logic [DW-1:0] peak_out
`endif
);

  localparam int AW = ACC_W - LOG2_N_DEF + LOG2_N;

  logic [AW-1:0]     r_acc;
  logic [LOG2_N-1:0] r_cnt;
  logic [DW-1:0]     r_rms;
  logic              r_vld;
  logic              r_ovr;

  logic [DW-1:0]     w_abs;
  logic [AW-1:0]     w_sq;
  logic [AW-1:0]     w_sum;
  logic [RAD_W-1:0]  w_mean;
  logic              w_close;
  logic              w_busy;
  logic              w_done;
  logic [DW-1:0]     w_root;

  // Magnitude squared is identical to the signed square.
  assign w_abs   = sample_in[DW-1] ? (~sample_in + 1'b1) : sample_in;
  assign w_sq    = AW'(w_abs) * AW'(w_abs);
  assign w_sum   = r_acc + w_sq;
  assign w_mean  = RAD_W'(w_sum >> LOG2_N);
  assign w_close = sample_valid && (r_cnt == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (sample_valid) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_close ? '0 : w_sum;
    end
  end

  isqrt_seq #(.W(DW)) u_sqrt (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_start    (w_close),
    .i_radicand (w_mean),
    .o_root     (w_root),
    .o_done     (w_done),
    .o_busy     (w_busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rms <= '0;
      r_vld <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_vld <= w_done;
      if (w_done) r_rms <= w_root;
      if (w_close && w_busy) r_ovr <= 1'b1;
    end
  end

  assign rms_out   = r_rms;
  assign rms_valid = r_vld;
  assign busy      = w_busy;
  assign overrun   = r_ovr;

`ifdef RMS_PEAK_HOLD_EN
  logic [DW-1:0] r_peak;
  logic [DW-1:0] r_peak_lat;
  logic [DW-1:0] r_peak_out;
  logic [DW-1:0] w_pk;

  assign w_pk = (w_abs > r_peak) ? w_abs : r_peak;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak     <= '0;
      r_peak_lat <= '0;
      r_peak_out <= '0;
    end else begin
      if (sample_valid) r_peak <= w_close ? '0 : w_pk;
      if (w_close && !w_busy) r_peak_lat <= w_pk;
      if (w_done) r_peak_out <= r_peak_lat;
    end
  end

  assign peak_out = r_peak_out;
`endif

endmodule

// File: tb/tb_rms_amplitude_meter.sv
// Self-checking bench for rms_amplitude_meter (LOG2_N=4 and LOG2_N=1).
// Peak checks are active when RMS_PEAK_HOLD_EN is defined.
module tb_rms_amplitude_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [21:0] sample_in;
  logic        sample_valid;
  logic [21:0] rms_out;
  logic        rms_valid;
  logic        busy;
  logic        overrun;
  logic [21:0] sample_in1;
  logic        sample_valid1;
  logic [21:0] rms_out1;
  logic        rms_valid1;
  logic        busy1;
  logic        overrun1;
`ifdef RMS_PEAK_HOLD_EN
  logic [21:0] peak_out;
  logic [21:0] peak_out1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [21:0] q_rms[$];
  logic [21:0] q_pk[$];
  logic [21:0] q1_rms[$];

  always #5 clk = ~clk;

  rms_amplitude_meter #(.LOG2_N(4)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .rms_out      (rms_out),
    .rms_valid    (rms_valid),
    .busy         (busy),
    .overrun      (overrun)
`ifdef RMS_PEAK_HOLD_EN
    ,
    .peak_out     (peak_out)
`endif
  );

  rms_amplitude_meter #(.LOG2_N(1)) u_dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in1),
    .sample_valid (sample_valid1),
    .rms_out      (rms_out1),
    .rms_valid    (rms_valid1),
    .busy         (busy1),
    .overrun      (overrun1)
`ifdef RMS_PEAK_HOLD_EN
    ,
    .peak_out     (peak_out1)
`endif
  );

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rms_valid === 1'b1) begin
      q_rms.push_back(rms_out);
`ifdef RMS_PEAK_HOLD_EN
      q_pk.push_back(peak_out);
`endif
    end
    if (reset_n === 1'b1 && rms_valid1 === 1'b1)
      q1_rms.push_back(rms_out1);
  end

  function automatic longint exp_rms(input longint s[$], input int l2);
    longint sum;
    longint m;
    longint r;
    sum = 0;
    foreach (s[i]) sum += s[i] * s[i];
    m = sum >>> l2;
    r = longint'($sqrt(real'(m)));
    while (r * r > m) r--;
    while ((r + 1) * (r + 1) <= m) r++;
    return r;
  endfunction

  function automatic longint exp_peak(input longint s[$]);
    longint p;
    p = 0;
    foreach (s[i]) begin
      if (s[i] > p) p = s[i];
      if (-s[i] > p) p = -s[i];
    end
    return p;
  endfunction

  task automatic strobe_main(input longint s, input int gap);
    sample_in = 22'(s);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic strobe_one(input longint s, input int gap);
    sample_in1 = 22'(s);
    sample_valid1 = 1'b1;
    @(negedge clk);
    sample_valid1 = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_win(input longint w[$], input int gap);
    foreach (w[i]) strobe_main(w[i], gap);
  endtask

  task automatic wait_main(input int n);
    int k;
    k = 0;
    while (q_rms.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic wait_one(input int n);
    int k;
    k = 0;
    while (q1_rms.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_checks++;
    if ({rms_out, rms_valid, busy, overrun} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0",
               {rms_out, rms_valid, busy, overrun});
    end
    n_checks++;
    if ({rms_out1, rms_valid1, busy1, overrun1} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outs1: got %h want 0",
               {rms_out1, rms_valid1, busy1, overrun1});
    end
`ifdef RMS_PEAK_HOLD_EN
    n_checks++;
    if (peak_out !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_peak: got %0d want 0", peak_out);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rms_valid, busy, overrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 000",
               {rms_valid, busy, overrun});
    end
  endtask

  task automatic test_constant;
    int n;
    for (int i = 0; i < 15; i++) strobe_main(625, 40);
    strobe_main(625, 1);
    n = 0;
    while (rms_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != 23) begin
      n_fail++;
      $display("FAIL latency: got %0d edges want 23", n);
    end
    n_checks++;
    if (rms_out !== 22'd625) begin
      n_fail++;
      $display("FAIL const_625: got %0d want 625", rms_out);
    end
    @(negedge clk);
    n_checks++;
    if (rms_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width: got %b want 0", rms_valid);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL const_ovr: got %b want 0", overrun);
    end
    n_checks++;
    if (q_rms.size() != 1) begin
      n_fail++;
      $display("FAIL const_count: got %0d want 1", q_rms.size());
    end
    q_rms.delete();
    q_pk.delete();
  endtask

  task automatic test_patterns;
    longint w[$];
    longint want[3];
    logic [21:0] got;
    want = '{3000, 1414, 2097152};
    for (int p = 0; p < 3; p++) begin
      w.delete();
      for (int i = 0; i < 16; i++) begin
        case (p)
          0:       w.push_back((i % 2 == 0) ? 3000 : -3000);
          1:       w.push_back((i % 2 == 0) ? 0 : 2000);
          default: w.push_back(-2097152);
        endcase
      end
      send_win(w, 30);
      wait_main(1);
      n_checks++;
      if (q_rms.size() != 1) begin
        n_fail++;
        $display("FAIL pat%0d_count: got %0d want 1", p, q_rms.size());
      end
      got = (q_rms.size() > 0) ? q_rms.pop_front() : 22'hx;
      n_checks++;
      if (got !== 22'(want[p])) begin
        n_fail++;
        $display("FAIL pat%0d_rms: got %0d want %0d", p, got, want[p]);
      end
`ifdef RMS_PEAK_HOLD_EN
      got = (q_pk.size() > 0) ? q_pk.pop_front() : 22'hx;
      n_checks++;
      if (got !== 22'(exp_peak(w))) begin
        n_fail++;
        $display("FAIL pat%0d_peak: got %0d want %0d", p, got, exp_peak(w));
      end
`endif
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL pat_ovr: got %b want 0", overrun);
    end
  endtask

  task automatic test_back_to_back;
    longint w[$];
    logic [21:0] got;
    for (int i = 0; i < 16; i++) w.push_back(625);
    for (int i = 0; i < 16; i++) w.push_back(1250);
    send_win(w, 2);
    wait_main(2);
    n_checks++;
    if (q_rms.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", q_rms.size());
    end
    got = (q_rms.size() > 0) ? q_rms.pop_front() : 22'hx;
    n_checks++;
    if (got !== 22'd625) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d want 625", got);
    end
    got = (q_rms.size() > 0) ? q_rms.pop_front() : 22'hx;
    n_checks++;
    if (got !== 22'd1250) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d want 1250", got);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ovr: got %b want 0", overrun);
    end
    q_rms.delete();
    q_pk.delete();
  endtask

  task automatic test_random;
    longint w[$];
    longint e_rms[$];
    longint e_pk[$];
    logic signed [21:0] t;
    logic [21:0] got;
    for (int k = 0; k < 4; k++) begin
      w.delete();
      for (int i = 0; i < 16; i++) begin
        t = 22'($urandom);
        if (k == 3) t = 22'($urandom_range(0, 4095)) - 22'sd2048;
        if (k == 1 && i == 5) t = -22'sd2097152;
        w.push_back(longint'(t));
      end
      e_rms.push_back(exp_rms(w, 4));
      e_pk.push_back(exp_peak(w));
      send_win(w, 3);
    end
    wait_main(4);
    n_checks++;
    if (q_rms.size() != 4) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d want 4", q_rms.size());
    end
    for (int k = 0; k < 4; k++) begin
      got = (q_rms.size() > 0) ? q_rms.pop_front() : 22'hx;
      n_checks++;
      if (got !== 22'(e_rms[k])) begin
        n_fail++;
        $display("FAIL rnd%0d_rms: got %0d want %0d", k, got, e_rms[k]);
      end
`ifdef RMS_PEAK_HOLD_EN
      got = (q_pk.size() > 0) ? q_pk.pop_front() : 22'hx;
      n_checks++;
      if (got !== 22'(e_pk[k])) begin
        n_fail++;
        $display("FAIL rnd%0d_peak: got %0d want %0d", k, got, e_pk[k]);
      end
`endif
    end
  endtask

  task automatic test_log2n1;
    longint a[$];
    longint b[$];
    logic [21:0] got;
    a = '{1200, -700};
    b = '{40000, 90000};
    strobe_one(a[0], 1);
    strobe_one(a[1], 11);
    strobe_one(b[0], 12);
    strobe_one(b[1], 1);
    wait_one(2);
    n_checks++;
    if (q1_rms.size() != 2) begin
      n_fail++;
      $display("FAIL coinc_count: got %0d want 2", q1_rms.size());
    end
    got = (q1_rms.size() > 0) ? q1_rms.pop_front() : 22'hx;
    n_checks++;
    if (got !== 22'(exp_rms(a, 1))) begin
      n_fail++;
      $display("FAIL coinc_first: got %0d want %0d", got, exp_rms(a, 1));
    end
    got = (q1_rms.size() > 0) ? q1_rms.pop_front() : 22'hx;
    n_checks++;
    if (got !== 22'(exp_rms(b, 1))) begin
      n_fail++;
      $display("FAIL coinc_second: got %0d want %0d", got, exp_rms(b, 1));
    end
    n_checks++;
    if (overrun1 !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_ovr: got %b want 0", overrun1);
    end
    a.delete();
    for (int i = 0; i < 6; i++) begin
      a.push_back(longint'($urandom_range(0, 2000000)) - 1000000);
      strobe_one(a[i], 1);
    end
    wait_one(1);
    repeat (40) @(negedge clk);
    n_checks++;
    if (q1_rms.size() != 1) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d want 1", q1_rms.size());
    end
    b = '{a[0], a[1]};
    got = (q1_rms.size() > 0) ? q1_rms.pop_front() : 22'hx;
    n_checks++;
    if (got !== 22'(exp_rms(b, 1))) begin
      n_fail++;
      $display("FAIL ovr_first: got %0d want %0d", got, exp_rms(b, 1));
    end
    n_checks++;
    if (overrun1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b want 1", overrun1);
    end
  endtask

  task automatic test_reset_during_run;
    logic [21:0] got;
    for (int i = 0; i < 16; i++) strobe_main(777, 2);
    for (int i = 0; i < 5; i++) strobe_main(30000, 2);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_busy: got %b want 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rms_out, rms_valid, busy, overrun} !== 25'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0",
               {rms_out, rms_valid, busy, overrun});
    end
    n_checks++;
    if (overrun1 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_ovr1: got %b want 0", overrun1);
    end
    q_rms.delete();
    q_pk.delete();
    q1_rms.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) strobe_main(100, 2);
    wait_main(1);
    repeat (30) @(negedge clk);
    n_checks++;
    if (q_rms.size() != 1) begin
      n_fail++;
      $display("FAIL post_rst_count: got %0d want 1", q_rms.size());
    end
    got = (q_rms.size() > 0) ? q_rms.pop_front() : 22'hx;
    n_checks++;
    if (got !== 22'd100) begin
      n_fail++;
      $display("FAIL post_rst_rms: got %0d want 100", got);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    sample_in1 = '0;
    sample_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_constant;
    test_patterns;
    test_back_to_back;
    test_random;
    test_log2n1;
    test_reset_during_run;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
